// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = sum_in - a_in (mod 2^WIDTH).
// One bit is processed per clock, LSB first. Operands are captured when a
// start request is accepted in IDLE. done pulses for one cycle once the
// result is complete.
//
// Ports:
//   clk     clock; all state updates on the rising edge
//   rst     asynchronous active-high reset
//   start   request; sampled only in IDLE
//   sum_in  minuend, captured on the accepting edge
//   a_in    subtrahend, captured on the accepting edge
//   busy    high while the FSM is not IDLE
//   done    one-cycle pulse; diff/borrow valid
//   diff    result; during SHIFT it shows partially shifted bits
//   borrow  final borrow, 1 iff sum_in < a_in (unsigned)
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg, areg;
  logic [CW-1:0]    cnt;
  logic             b;

  // Current bit-step of the ripple borrow chain.
  logic d_bit, b_nxt;
  always_comb begin
    d_bit = sreg[0] ^ areg[0] ^ b;
    b_nxt = (~sreg[0] & areg[0]) | (~(sreg[0] ^ areg[0]) & b);
  end

  assign busy = (state != IDLE);
  // DONE lasts exactly one cycle, so the pulse falls out of the state.
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      areg   <= '0;
      cnt    <= '0;
      b      <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            sreg  <= sum_in;
            areg  <= a_in;
            b     <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so that after WIDTH steps the
          // first (LSB) bit has walked down to diff[0].
          diff <= {d_bit, diff[WIDTH-1:1]};
          sreg <= sreg >> 1;
          areg <= areg >> 1;
          b    <= b_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            borrow <= b_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
